weight_mac_cell: RTL
====================

Name: weight_mac_cell

Overview:
Parametrised systolic dot-product cell for the inference array. Streams (index, value) pairs through a 1-cycle pass-through pipeline and multiply-accumulates each value against a runtime-loadable weight bank. Emits a completed sum onto a daisy-chained result bus whose MSB is a valid flag. A small local result FIFO absorbs collisions with upstream results instead of losing them.

Parameters:
DATA_WIDTH, 32, width of streamed value.
INDEX_WIDTH, 8, width of streamed index.
WEIGHT_WIDTH, 8, width of each stored weight, unsigned.
WEIGHT_AMOUNT, 4, number of weights (dot-product length), >=2.
ACC_WIDTH, 32, accumulator and result payload width.
RESULT_FIFO_DEPTH, 2, local completed-result queue depth, >=1.
WEIGHTS_INIT, all zero, WEIGHT_AMOUNT*WEIGHT_WIDTH bits; weight i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; reset value of the weight bank.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
weight_load_en  in  1  write one weight this cycle.
weight_load_addr  in  INDEX_WIDTH  weight slot; writes with addr >= WEIGHT_AMOUNT are ignored.
weight_load_data  in  WEIGHT_WIDTH  weight value.
input_enable  in  1  stream beat valid.
input_index  in  INDEX_WIDTH  position of the beat within the vector.
input_value  in  DATA_WIDTH  operand.
input_result  in  ACC_WIDTH+1  upstream result; MSB = valid.
output_enable  out  1  registered input_enable.
output_index  out  INDEX_WIDTH  registered input_index.
output_value  out  DATA_WIDTH  registered input_value.
output_result  out  ACC_WIDTH+1  downstream result; MSB = valid.
result_dropped  out  1  sticky: a completed result was lost because the FIFO was full.

Behaviour:
- Reset (async): all outputs 0, accumulator 0, FIFO empty, result_dropped 0, weights = WEIGHTS_INIT.
- Pass-through: on each edge, output_enable/index/value <= input_*. When input_enable=0, index and value outputs are 0. Latency is 1 cycle.
- Product: input_value * weight[input_index], zero-extended and truncated to ACC_WIDTH. The sum wraps modulo 2^ACC_WIDTH.
- Accumulation, only when input_enable=1:
  - index 0: acc <= product.
  - 0 < index < WEIGHT_AMOUNT-1: acc <= acc + product.
  - index == WEIGHT_AMOUNT-1: completion C = acc + product; acc <= 0.
  - index >= WEIGHT_AMOUNT: no accumulation; the beat still passes through.
- Weight write: weight_load_en writes at the edge. A beat in the same cycle reading the same slot uses the old weight.
- Result bus priority at each edge, first match wins:
  1. input_result valid: forward it unchanged. A completion C, if any, is pushed into the FIFO.
  2. FIFO non-empty: output_result <= {1, head}, pop. A completion C, if any, is pushed (push and pop may occur together).
  3. Completion C present: output_result <= {1, C}, bypassing the FIFO, so latency matches a plain cell.
  4. Otherwise output_result <= 0.
- FIFO full, push required, no pop in that cycle: C is discarded and result_dropped <= 1. The flag stays set until rst.
- FIFO order is strictly first-in first-out. The count saturates at RESULT_FIFO_DEPTH and never wraps.
- Reset mid-vector: the partial sum and queued results are discarded. The next vector must start at index 0.

Decomposition:
- Package weight_mac_pkg: result valid-bit position helper and a product/accumulate width function.
- Sub-module result_fifo (parametrised depth/width, push/pop/count/full/empty, async reset) is natural.
- The MAC, weight bank and priority mux stay in the top.

Test Plan:
1. Weights [1,2,3,4]; beats idx0..3 with values 5,6,7,8; no upstream result -> output_result = {1,70} at the edge after idx3; output_value trails input by 1 cycle.
2. Same vector, but input_result = {1,99} on the completion cycle -> output {1,99} that cycle, then {1,70} on the next cycle.
3. DEPTH=2; upstream valid held for 3 back-to-back completions (70,70,70) -> first two queued, third dropped, result_dropped=1. After upstream goes idle: {1,70},{1,70}, then 0.
4. Write weight slot 2 := 10 on the same cycle idx2 (value 7) arrives -> sum uses old weight 3 (70). The next vector uses 10: 5+12+70+32 = 119.
5. ACC_WIDTH=8, weights [255,255,255,255], values 255 -> result payload wraps to (4*65025) mod 256 = 4.
6. Assert rst after idx1 beat -> all outputs 0 immediately. A fresh vector idx0..3 (values 5,6,7,8, weights [1,2,3,4]) then yields {1,70}; idx=7 beats pass through without affecting acc.

Source files
------------

// File: rtl/weight_mac_pkg.sv
// Shared helpers for the weight MAC cell: where the result-bus valid flag
// lives and how wide the internal product must be before truncation.
package weight_mac_pkg;

  // The valid flag sits directly above the ACC_WIDTH-bit payload.
  function automatic int result_valid_bit(input int acc_width);
    return acc_width;
  endfunction

  // Wide enough to hold the full product and to zero-extend into the accumulator.
  function automatic int product_width(input int data_width, input int weight_width,
                                       input int acc_width);
    return (data_width + weight_width > acc_width) ? data_width + weight_width : acc_width;
  endfunction

endpackage

// File: rtl/weight_mac_cell_result_fifo.sv
// Small circular FIFO holding completed sums that could not go out on the
// result bus because upstream traffic or older queued results had priority.
// A push is accepted when full only if a pop happens in the same cycle.
module result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; count saturates at DEPTH by construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Payload storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/weight_mac_cell.sv
// Systolic dot-product cell: passes (index, value) beats downstream with one
// cycle of latency, multiply-accumulates them against a loadable weight bank
// and merges finished sums onto a daisy-chained result bus (MSB = valid).
module weight_mac_cell
  import weight_mac_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int INDEX_WIDTH       = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int WEIGHT_AMOUNT     = 4,
  parameter int ACC_WIDTH         = 32,
  parameter int RESULT_FIFO_DEPTH = 2,
  parameter logic [WEIGHT_AMOUNT*WEIGHT_WIDTH-1:0] WEIGHTS_INIT = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    weight_load_en,
  input  logic [INDEX_WIDTH-1:0]  weight_load_addr,
  input  logic [WEIGHT_WIDTH-1:0] weight_load_data,
  input  logic                    input_enable,
  input  logic [INDEX_WIDTH-1:0]  input_index,
  input  logic [DATA_WIDTH-1:0]   input_value,
  input  logic [ACC_WIDTH:0]      input_result,
  output logic                    output_enable,
  output logic [INDEX_WIDTH-1:0]  output_index,
  output logic [DATA_WIDTH-1:0]   output_value,
  output logic [ACC_WIDTH:0]      output_result,
  output logic                    result_dropped
);

  localparam int VB    = result_valid_bit(ACC_WIDTH);
  localparam int EXT_W = product_width(DATA_WIDTH, WEIGHT_WIDTH, ACC_WIDTH);
  localparam int CNT_W = $clog2(RESULT_FIFO_DEPTH + 1);

  logic [WEIGHT_WIDTH-1:0] weights [WEIGHT_AMOUNT];
  logic [WEIGHT_WIDTH-1:0] weight_sel;
  logic [EXT_W-1:0]        product_ext;
  logic [ACC_WIDTH-1:0]    product;
  logic [ACC_WIDTH-1:0]    acc;
  logic [ACC_WIDTH-1:0]    completion;
  logic                    idx_first;
  logic                    idx_mid;
  logic                    idx_last;
  logic                    comp_valid;
  logic                    up_valid;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [ACC_WIDTH-1:0]    fifo_head;
  logic [CNT_W-1:0]        fifo_count;

  // Select the weight for the current beat; out-of-range indices read as zero.
  always_comb begin
    weight_sel = '0;
    for (int i = 0; i < WEIGHT_AMOUNT; i++) begin
      if (input_index == INDEX_WIDTH'(i)) weight_sel = weights[i];
    end
  end

  assign product_ext = EXT_W'(input_value) * EXT_W'(weight_sel);
  assign product     = product_ext[ACC_WIDTH-1:0];
  assign idx_first   = (input_index == '0);
  assign idx_last    = (input_index == INDEX_WIDTH'(WEIGHT_AMOUNT - 1));
  assign idx_mid     = !idx_first && (32'(input_index) < WEIGHT_AMOUNT - 1);
  assign comp_valid  = input_enable && idx_last;
  assign completion  = acc + product;
  assign up_valid    = input_result[VB];

  // Upstream results and older queued sums go first; a new sum queues behind them.
  assign fifo_pop  = !up_valid && !fifo_empty;
  assign fifo_push = comp_valid && (up_valid || !fifo_empty);
  assign fifo_full = (fifo_count == CNT_W'(RESULT_FIFO_DEPTH));

  result_fifo #(
    .DEPTH (RESULT_FIFO_DEPTH),
    .WIDTH (ACC_WIDTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (completion),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (),
    .empty (fifo_empty)
  );

  // Weight bank: writes land at the edge, so a same-cycle beat sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WEIGHT_AMOUNT; i++)
        weights[i] <= WEIGHTS_INIT[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end else if (weight_load_en) begin
      for (int i = 0; i < WEIGHT_AMOUNT; i++)
        if (weight_load_addr == INDEX_WIDTH'(i)) weights[i] <= weight_load_data;
    end
  end

  // Beat pass-through; idle beats are forced to zero downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_enable <= 1'b0;
      output_index  <= '0;
      output_value  <= '0;
    end else begin
      output_enable <= input_enable;
      output_index  <= input_enable ? input_index : '0;
      output_value  <= input_enable ? input_value : '0;
    end
  end

  // Accumulator: index 0 restarts, middle indices add, last index clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (input_enable) begin
      if (idx_first)     acc <= product;
      else if (idx_mid)  acc <= acc + product;
      else if (idx_last) acc <= '0;
    end
  end

  // Result bus arbitration: upstream, then queued sums, then a fresh sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_result <= '0;
    end else if (up_valid) begin
      output_result <= input_result;
    end else if (!fifo_empty) begin
      output_result <= {1'b1, fifo_head};
    end else if (comp_valid) begin
      output_result <= {1'b1, completion};
    end else begin
      output_result <= '0;
    end
  end

  // Sticky loss flag: a sum had to queue but the queue was full and not draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_dropped <= 1'b0;
    end else if (fifo_push && fifo_full && !fifo_pop) begin
      result_dropped <= 1'b1;
    end
  end

endmodule
